// File: rtl/ex_case_rx_if.sv
// Sample stream from the ex_case transmitter: one dv/data pair per sclk.
interface ex_case_rx_if;
  logic       i_dv;
  logic [7:0] i_data;

  modport master (output i_dv, output i_data);
  modport slave  (input  i_dv, input  i_data);
endinterface

// File: rtl/ex_case_rx.sv
// Receive checker for the 7-slot ex_case stream: hunt for sync, confirm
// alignment, then check every slot, count errors and forward payload.
module ex_case_rx #(
  parameter int unsigned FRAME_LEN = 7,
  parameter logic [7:0]  SYNC_WORD = 8'h07,
  parameter logic [7:0]  PLD_WORD  = 8'h05,
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned LOSS_CNT  = 2
) (
  input  logic        sclk,
  input  logic        rst,
  ex_case_rx_if.slave rx,
  input  logic        i_clr,
  output logic        o_locked,
  output logic [2:0]  o_slot,
  output logic        o_err,
  output logic [15:0] o_err_cnt,
  output logic        o_frame_ok,
  output logic        o_pld_dv,
  output logic [7:0]  o_pld_data
);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [2:0] LAST_SLOT = 3'(FRAME_LEN - 1);
  localparam logic [3:0] LOCK_TGT  = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TGT  = 4'(LOSS_CNT);

  logic [1:0] state;
  logic [2:0] slot;       // slot expected for the current sample
  logic [3:0] good_cnt;
  logic [3:0] bad_cnt;
  logic       frame_bad;

  logic is_sync;
  logic slot_ok;
  logic is_last;
  logic is_pld;

  always_comb begin
    is_sync = rx.i_dv && (rx.i_data == SYNC_WORD);
    is_last = (slot == LAST_SLOT);
    is_pld  = (slot >= 3'd2);
    if (slot == 3'd0)
      slot_ok = is_sync;
    else if (slot == 3'd1)
      slot_ok = !rx.i_dv;
    else
      slot_ok = rx.i_dv && (rx.i_data == PLD_WORD);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state      <= ST_HUNT;
      slot       <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      frame_bad  <= 1'b0;
      o_locked   <= 1'b0;
      o_slot     <= '0;
      o_err      <= 1'b0;
      o_err_cnt  <= '0;
      o_frame_ok <= 1'b0;
      o_pld_dv   <= 1'b0;
      o_pld_data <= '0;
    end else begin
      o_err      <= 1'b0;
      o_frame_ok <= 1'b0;
      o_pld_dv   <= 1'b0;
      o_slot     <= '0;
      case (state)
        ST_HUNT: begin
          if (is_sync) begin
            state    <= ST_CONFIRM;
            slot     <= 3'd1;
            good_cnt <= '0;
          end
        end
        ST_CONFIRM: begin
          o_slot <= slot;
          if (!slot_ok) begin
            o_err <= 1'b1;
            // A failing sample that is itself a sync word restarts the confirm
            if (is_sync) begin
              slot     <= 3'd1;
              good_cnt <= '0;
            end else begin
              state <= ST_HUNT;
              slot  <= '0;
            end
          end else if (is_last) begin
            slot     <= '0;
            good_cnt <= good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_TGT) begin
              state     <= ST_LOCKED;
              o_locked  <= 1'b1;
              bad_cnt   <= '0;
              frame_bad <= 1'b0;
            end
          end else begin
            slot <= slot + 3'd1;
          end
        end
        ST_LOCKED: begin
          o_slot <= slot;
          if (!slot_ok) begin
            o_err     <= 1'b1;
            frame_bad <= 1'b1;
          end
          if (is_pld) begin
            o_pld_dv   <= rx.i_dv;
            o_pld_data <= rx.i_data;
          end
          if (is_last) begin
            slot      <= '0;
            frame_bad <= 1'b0;
            if (slot_ok && !frame_bad) begin
              o_frame_ok <= 1'b1;
              bad_cnt    <= '0;
            end else begin
              bad_cnt <= bad_cnt + 4'd1;
              if (bad_cnt + 4'd1 == LOSS_TGT) begin
                state    <= ST_HUNT;
                o_locked <= 1'b0;
              end
            end
          end else begin
            slot <= slot + 3'd1;
          end
        end
        default: begin
          state    <= ST_HUNT;
          slot     <= '0;
          o_locked <= 1'b0;
        end
      endcase

      if (i_clr)
        o_err_cnt <= '0;
      else if ((state == ST_LOCKED) && !slot_ok && (o_err_cnt != 16'hFFFF))
        o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

endmodule
